// File: rtl/time_counter.sv
// time_counter: BCD seconds/minutes/hours timekeeping datapath.
// Counts from a 1 Hz enable pulse. Accepts the SECCLR, MININC and HOURINC
// adjust commands from the mode controller. All outputs are registered.
//
// Optional build macro CLOCK12_EN selects 12-hour counting with a PM flag.
// HOUR then runs 12, 01 .. 11, and PM toggles on every step out of 11.
// Without the macro the counter is 24-hour (00..23) and PM is tied low.
//
// Handshake: none. Every input is a level sampled at each rising CLK edge,
// and its effect is visible on the outputs right after that edge.
// A level held for N cycles therefore acts N times.
module time_counter #(
  parameter logic [7:0] HOUR_INIT = 8'h00,
  parameter logic [7:0] MIN_INIT  = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SECCLR,
  input  logic       MININC,
  input  logic       HOURINC,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
  output logic [7:0] HOUR,
  output logic       HOURCARRY,
  output logic       PM
);

`ifdef CLOCK12_EN
  // 12-hour dials have no hour zero, so an all-zero init means 12.
  localparam logic [7:0] HOUR_RST = (HOUR_INIT == 8'h00) ? 8'h12 : HOUR_INIT;
`else
  localparam logic [7:0] HOUR_RST = HOUR_INIT;
`endif

  // ------------------------------------------------------------------
  // BCD step helpers. Each helper takes the present value and returns
  // the value after one step. Any illegal encoding (a units digit above
  // 9, or a value beyond the field range) goes to the field's first
  // legal value. The carry logic further down compares against the exact
  // top value, so a wrap caused this way can never raise a carry.
  // ------------------------------------------------------------------

  // Modulo-60 step, shared by seconds and minutes.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd5) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

`ifdef CLOCK12_EN
  // 12-hour step: 12 -> 01 -> ... -> 11 -> 12. Anything else goes to 01.
  function automatic logic [7:0] hour12_inc(input logic [7:0] v);
    logic [7:0] r;
    logic       legal;
    legal = ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
            ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    if (!legal)              r = 8'h01;
    else if (v == 8'h12)     r = 8'h01;
    else if (v == 8'h09)     r = 8'h10;
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction
`else
  // 24-hour step: 00 .. 23 -> 00. Anything out of range goes to 00.
  function automatic logic [7:0] hour24_inc(input logic [7:0] v);
    logic [7:0] r;
    logic       legal;
    legal = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd2) &&
            !((v[7:4] == 4'd2) && (v[3:0] > 4'd3));
    if (!legal)               r = 8'h00;
    else if (v == 8'h23)      r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction
`endif

  // ------------------------------------------------------------------
  // Next-state datapath
  // ------------------------------------------------------------------
  logic [7:0] sec_next;
  logic [7:0] min_next;
  logic [7:0] hour_next;
  logic       seccarry;
  logic       minstep;
  logic       mincarry;
  logic       hourstep;
  logic       pm_next;

  // Seconds: a clear wins over counting and swallows the carry into minutes.
  always_comb begin
    sec_next = SEC;
    seccarry = 1'b0;
    if (SECCLR) begin
      sec_next = 8'h00;
    end else if (EN1HZ) begin
      sec_next = bcd60_inc(SEC);
      seccarry = (SEC == 8'h59);
    end
  end

  // Minutes: the natural carry and the adjust pulse OR into a single step.
  // Only a carry-sourced wrap passes a carry on to the hours.
  always_comb begin
    min_next = MIN;
    minstep  = seccarry | MININC;
    mincarry = 1'b0;
    if (minstep) begin
      min_next = bcd60_inc(MIN);
      mincarry = seccarry && (MIN == 8'h59);
    end
  end

  // Hours: one step for either source. In 12-hour mode, leaving 11 flips PM.
  always_comb begin
    hour_next = HOUR;
    hourstep  = mincarry | HOURINC;
    pm_next   = 1'b0;
`ifdef CLOCK12_EN
    pm_next = PM;
    if (hourstep) begin
      hour_next = hour12_inc(HOUR);
      if (HOUR == 8'h11) pm_next = ~PM;
    end
`else
    if (hourstep) hour_next = hour24_inc(HOUR);
`endif
  end

  // ------------------------------------------------------------------
  // State registers. Reset takes priority over any step, including a
  // full rollover in the same cycle, so HOURCARRY is also cleared then.
  // ------------------------------------------------------------------

  // Time-of-day registers and the natural-carry hour pulse.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      SEC       <= 8'h00;
      MIN       <= MIN_INIT;
      HOUR      <= HOUR_RST;
      HOURCARRY <= 1'b0;
    end else begin
      SEC       <= sec_next;
      MIN       <= min_next;
      HOUR      <= hour_next;
      HOURCARRY <= mincarry;
    end
  end

`ifdef CLOCK12_EN
  // Meridiem flag register.
  always_ff @(posedge CLK) begin
    if (!RST) PM <= 1'b0;
    else      PM <= pm_next;
  end
`else
  // 24-hour build: the meridiem flag is not used.
  assign PM = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: self-checking bench for time_counter.
// The bench keeps an integer reference model. Each driven cycle pushes the
// model's expected outputs onto exp_q, and that entry is popped and compared
// right after the clock edge. Directed sequences cover the listed scenarios;
// a random phase follows. Build with +define+CLOCK12_EN for 12-hour mode.
module tb_time_counter;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       en1hz;
  logic       secclr;
  logic       mininc;
  logic       hourinc;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic       hourcarry;
  logic       pm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  time_counter #(
    .HOUR_INIT(8'h09),
    .MIN_INIT (8'h30)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .EN1HZ    (en1hz),
    .SECCLR   (secclr),
    .MININC   (mininc),
    .HOURINC  (hourinc),
    .SEC      (sec),
    .MIN      (min),
    .HOUR     (hour),
    .HOURCARRY(hourcarry),
    .PM       (pm)
  );

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_miss;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_sec;
  int m_min;
  int m_hour;
  bit m_hc;
  bit m_pm;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit c, input bit mi, input bit hi);
    bit sc;
    bit mc;
    if (!r) begin
      m_sec = 0; m_min = 30; m_hour = 9; m_hc = 0; m_pm = 0;
    end else begin
      sc = e && !c && (m_sec == 59);
      if (c)      m_sec = 0;
      else if (e) m_sec = (m_sec + 1) % 60;
      mc = sc && (m_min == 59);
      if (sc || mi) m_min = (m_min + 1) % 60;
      if (mc || hi) begin
`ifdef CLOCK12_EN
        if (m_hour == 11) begin
          m_hour = 12;
          m_pm = !m_pm;
        end else if (m_hour == 12) begin
          m_hour = 1;
        end else begin
          m_hour = m_hour + 1;
        end
`else
        m_hour = (m_hour + 1) % 24;
`endif
      end
      m_hc = mc;
    end
  endtask

  // Outputs packed as {6'b0, hc, pm, HOUR, MIN, SEC}.
  function automatic logic [31:0] model_vec();
    return {6'd0, m_hc, m_pm, to_bcd(m_hour), to_bcd(m_min), to_bcd(m_sec)};
  endfunction

  function automatic logic [31:0] dut_hms();
    return {8'd0, hour, min, sec};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit e, input bit c, input bit mi, input bit hi);
    logic [31:0] got;
    @(negedge clk);
    rst = r; en1hz = e; secclr = c; mininc = mi; hourinc = hi;
    model_step(r, e, c, mi, hi);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    got = {6'd0, hourcarry, pm, hour, min, sec};
    check("cycle", got, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 0, 0, 0, 0);
  endtask

  task automatic tick(input int n);
    repeat (n) drive(1, 1, 0, 0, 0);
  endtask

  task automatic min_adj(input int n);
    repeat (n) drive(1, 0, 0, 1, 0);
  endtask

  task automatic hour_adj(input int n);
    repeat (n) drive(1, 0, 0, 0, 1);
  endtask

  // Watchdog: the run is a fixed number of cycles, so this should never fire.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b0; en1hz = 1'b0; secclr = 1'b0; mininc = 1'b0; hourinc = 1'b0;

    // Reset held two cycles, with counting requested to show reset wins.
    drive(0, 1, 0, 1, 1);
    check("rst_hms", dut_hms(), 32'h0009_3000);
    check("rst_hc", 32'(hourcarry), 32'd0);
    drive(0, 0, 0, 0, 0);
    check("rst_pm", 32'(pm), 32'd0);

`ifndef CLOCK12_EN
    // Full rollover from 23:59:58.
    hour_adj(14); min_adj(29); tick(58);
    check("pre_roll", dut_hms(), 32'h0023_5958);
    tick(1);
    check("roll_59", dut_hms(), 32'h0023_5959);
    check("roll_hc0", 32'(hourcarry), 32'd0);
    tick(1);
    check("roll_00", dut_hms(), 32'h0000_0000);
    check("roll_hc1", 32'(hourcarry), 32'd1);
    idle(1);
    check("roll_hc_end", 32'(hourcarry), 32'd0);

    // SECCLR beats EN1HZ at 00:10:59; the minute does not move.
    min_adj(10); tick(59);
    drive(1, 1, 1, 0, 0);
    check("clr_prio", dut_hms(), 32'h0000_1000);

    // MININC wrap at 05:59 leaves the hour alone.
    hour_adj(5); min_adj(49);
    drive(1, 0, 0, 1, 0);
    check("min_wrap", dut_hms(), 32'h0005_0000);

    // HOURINC wrap at 23:07 leaves minutes alone; no HOURCARRY.
    min_adj(7); hour_adj(18);
    drive(1, 0, 0, 0, 1);
    check("hour_wrap", dut_hms(), 32'h0000_0700);
    check("hour_wrap_hc", 32'(hourcarry), 32'd0);

    // EN1HZ carry and MININC together at 14:29:59 make a single step.
    hour_adj(14); min_adj(22); tick(59);
    drive(1, 1, 0, 1, 0);
    check("simul", dut_hms(), 32'h0014_3000);

    // Reset during a full rollover at 23:59:59.
    hour_adj(9); min_adj(29); tick(59);
    check("pre_mid", dut_hms(), 32'h0023_5959);
    drive(0, 1, 0, 0, 0);
    check("mid_rst", dut_hms(), 32'h0009_3000);
    check("mid_rst_hc", 32'(hourcarry), 32'd0);
`else
    // 11:59:59 AM -> 12:00:00 PM.
    hour_adj(2); min_adj(29); tick(59);
    check("pre_noon", dut_hms(), 32'h0011_5959);
    check("pre_noon_pm", 32'(pm), 32'd0);
    tick(1);
    check("noon", dut_hms(), 32'h0012_0000);
    check("noon_pm", 32'(pm), 32'd1);
    check("noon_hc", 32'(hourcarry), 32'd1);

    // 12:59:59 PM -> 01:00:00 PM.
    min_adj(59); tick(59);
    tick(1);
    check("one_pm", dut_hms(), 32'h0001_0000);
    check("one_pm_pm", 32'(pm), 32'd1);

    // HOURINC from 11 PM: 12 AM, then 01 AM.
    hour_adj(10);
    check("eleven", {24'd0, hour}, 32'h11);
    hour_adj(1);
    check("midnight", {24'd0, hour}, 32'h12);
    check("midnight_pm", 32'(pm), 32'd0);
    check("midnight_hc", 32'(hourcarry), 32'd0);
    hour_adj(1);
    check("one_am", {24'd0, hour}, 32'h01);
    check("one_am_pm", 32'(pm), 32'd0);
`endif

    // Random phase with occasional resets and bursts of adjust levels.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
